oc_multi: RTL and testbench
===========================

OC_MULTI -- requirements
Module: oc_multi

Interface
REQ-001 Parameter N_CH, default 4, number of compare channels (1..16).
REQ-002 Parameter TW, default 32, timer/compare width (8..32); register data bus fixed at 32 bits.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 addr_i  in  8  register word address.
REQ-006 data_i  in  32  write data; rd_i  in  1  read strobe; wr_i  in  1  write strobe.
REQ-007 data_o  out  32  read data, registered.
REQ-008 tm1, tm2  in  TW  timer counts; tm1_of, tm2_of  in  1  one-cycle overflow pulses.
REQ-009 outs  out  N_CH  compare outputs, registered.
REQ-010 irq_o  out  1  interrupt, registered, level.

Function
REQ-011 Map: channel c CONF at 2c, OCR at 2c+1; STATUS at 0x40; IRQEN at 0x41; unmapped reads return 0, unmapped writes ignored.
REQ-012 CONF bits: [2:0] mode, [3] timer select (0 = tm1, 1 = tm2), [4] preload enable; other bits read 0.
REQ-013 Modes: 0 off, 1 set-on-match, 2 clear-on-match, 3 toggle-on-match, 4 PWM-high, 5 PWM-low; 6, 7 behave as off.
REQ-014 OCR write updates shadow (TW LSBs); preload=0: active copy loads next cycle; preload=1: active copy loads on selected timer's overflow pulse.
REQ-015 OCR read returns shadow; CONF/STATUS/IRQEN reads return current value.
REQ-016 Read latency one cycle: data_o valid the cycle after rd_i; holds value until next read.
REQ-017 Read and write to same address in same cycle: data_o returns pre-write value.
REQ-018 Match event: selected timer == active OCR while previous cycle was not equal (one event per equality episode).
REQ-019 Output updates the cycle after the match event or overflow pulse.
REQ-020 Modes 1/2/3: on match, output goes 1 / 0 / inverted respectively; otherwise held.
REQ-021 Mode 4: overflow sets output 1, match clears to 0; mode 5 is the exact inverse.
REQ-022 Overflow and match in same cycle (PWM): match wins; active OCR = 0 gives constant 0 (mode 4) / 1 (mode 5).
REQ-023 Overflow-triggered preload and match in same cycle: match compares against old active value.
REQ-024 CONF write changing mode forces the output to idle level next cycle: 1 for modes 2 and 5, 0 otherwise.
REQ-025 Modes 0/6/7: output 0; match events still set STATUS.
REQ-026 STATUS[c] sets on channel c match; write-1-to-clear; set and clear in same cycle: set wins.
REQ-027 irq_o = OR of (STATUS & IRQEN), registered one cycle.
REQ-028 Timer select change takes effect next cycle; the equality history is cleared so an immediate equality counts as an event.

Reset
REQ-029 On rst low, asynchronously: CONF, OCR shadow/active, STATUS, IRQEN, data_o, outs, irq_o, equality history all 0.
REQ-030 Reset mid-PWM period: outs goes 0 immediately; operation resumes at the first overflow after release, once reconfigured.

Structure
REQ-031 Package oc_pkg holds the mode enum, CONF bit positions, register offsets and STATUS/IRQEN addresses.
REQ-032 Sub-module oc_channel (one per channel, generate loop) holds CONF, shadow/active OCR, match detection and output logic; top holds decode, read mux, STATUS, IRQEN, irq.

Verification
REQ-033 Ch0 mode 1, OCR=10, tm1 counts 0..20 -> outs[0] rises the cycle after tm1=10, STATUS[0]=1.
REQ-034 Ch1 mode 4, tm2 sel, OCR=25, tm2 wraps at 99 with tm2_of -> outs[1] high 25 cycles per 100-cycle period.
REQ-035 Ch2 mode 4, preload=1, OCR 25->75 written mid-period -> duty changes only after next overflow; OCR read returns 75 immediately.
REQ-036 Ch3 mode 3, tm1 held at OCR for 5 cycles -> single toggle, single STATUS set; IRQEN[3]=1 -> irq_o high; W1C coinciding with new match -> STATUS stays 1.
REQ-037 Mode 5, OCR=0 -> outs constant 1; rst asserted mid-run -> outs, data_o, irq_o 0 without a clock edge.

Source files
------------

// File: rtl/oc_pkg.sv
// oc_pkg: mode encoding, CONF field layout and register map shared by the
// output-compare top and its per-channel slices.
package oc_pkg;
   typedef enum logic [2:0] {
      M_OFF, M_SET, M_CLR, M_TGL, M_PWMH, M_PWML, M_RSV6, M_RSV7
   } oc_mode_e;

   localparam int CONF_W        = 5;
   localparam int CONF_MODE_LSB = 0;
   localparam int CONF_MODE_W   = 3;
   localparam int CONF_SEL      = 3;
   localparam int CONF_PRE      = 4;

   localparam int OFF_CONF = 0;
   localparam int OFF_OCR  = 1;

   localparam logic [7:0] ADDR_STATUS = 8'h40;
   localparam logic [7:0] ADDR_IRQEN  = 8'h41;

   function automatic logic idle_level(input oc_mode_e m);
      return (m == M_CLR) || (m == M_PWML);
   endfunction
endpackage

// File: rtl/oc_channel.sv
// oc_channel: one compare channel -- CONF, shadow/active OCR, edge-qualified
// match detection and the registered compare output.
module oc_channel
   import oc_pkg::*;
#(
   parameter int TW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_conf_we,
   input  logic              i_ocr_we,
   input  logic [TW-1:0]     i_wdata,
   input  logic [TW-1:0]     i_tm1,
   input  logic [TW-1:0]     i_tm2,
   input  logic              i_tm1_of,
   input  logic              i_tm2_of,
   output logic [CONF_W-1:0] o_conf,
   output logic [TW-1:0]     o_shadow,
   output logic              o_match,
   output logic              o_out
);
   logic [CONF_W-1:0] r_conf;
   logic [TW-1:0]     r_shadow, r_active;
   logic              r_eq_prev, r_out;
   logic [CONF_W-1:0] w_new_conf;
   oc_mode_e          w_mode, w_new_mode;
   logic [TW-1:0]     w_tm;
   logic              w_of, w_eq, w_next, w_mode_chg, w_sel_chg;

   assign w_new_conf = i_wdata[CONF_W-1:0];
   assign w_mode     = oc_mode_e'(r_conf[CONF_MODE_LSB +: CONF_MODE_W]);
   assign w_new_mode = oc_mode_e'(w_new_conf[CONF_MODE_LSB +: CONF_MODE_W]);
   assign w_mode_chg = i_conf_we && (w_new_mode != w_mode);
   assign w_sel_chg  = i_conf_we && (w_new_conf[CONF_SEL] != r_conf[CONF_SEL]);
   assign w_tm       = r_conf[CONF_SEL] ? i_tm2 : i_tm1;
   assign w_of       = r_conf[CONF_SEL] ? i_tm2_of : i_tm1_of;
   assign w_eq       = (w_tm == r_active);
   assign o_match    = w_eq && !r_eq_prev;

   // In PWM modes a match outranks a simultaneous overflow.
   always_comb begin
      w_next = 1'b0;
      case (w_mode)
         M_SET:   w_next = o_match | r_out;
         M_CLR:   w_next = !o_match & r_out;
         M_TGL:   w_next = o_match ^ r_out;
         M_PWMH:  w_next = o_match ? 1'b0 : (w_of | r_out);
         M_PWML:  w_next = o_match ? 1'b1 : (!w_of & r_out);
         default: w_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_conf    <= '0;
         r_shadow  <= '0;
         r_active  <= '0;
         r_eq_prev <= 1'b0;
         r_out     <= 1'b0;
      end else begin
         if (i_conf_we) r_conf <= w_new_conf;
         if (i_ocr_we) r_shadow <= i_wdata;
         if (!r_conf[CONF_PRE] || w_of) r_active <= r_shadow;
         r_eq_prev <= w_eq && !w_sel_chg;
         r_out     <= w_mode_chg ? idle_level(w_new_mode) : w_next;
      end
   end

   assign o_conf   = r_conf;
   assign o_shadow = r_shadow;
   assign o_out    = r_out;
endmodule

// File: rtl/oc_multi.sv
// oc_multi: multi-channel output-compare unit -- register decode, registered
// read mux, STATUS (W1C), IRQEN and the level interrupt.
module oc_multi
   import oc_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int TW   = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      addr_i,
   input  logic [31:0]     data_i,
   input  logic            rd_i,
   input  logic            wr_i,
   output logic [31:0]     data_o,
   input  logic [TW-1:0]   tm1,
   input  logic [TW-1:0]   tm2,
   input  logic            tm1_of,
   input  logic            tm2_of,
   output logic [N_CH-1:0] outs,
   output logic            irq_o
);
   logic [CONF_W-1:0] w_conf   [N_CH];
   logic [TW-1:0]     w_shadow [N_CH];
   logic [N_CH-1:0]   w_match, w_clr;
   logic [N_CH-1:0]   r_status, r_irqen;
   logic [31:0]       w_rdata;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      oc_channel #(.TW(TW)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_conf_we(wr_i && (addr_i == 8'(2 * g + OFF_CONF))),
         .i_ocr_we (wr_i && (addr_i == 8'(2 * g + OFF_OCR))),
         .i_wdata  (data_i[TW-1:0]),
         .i_tm1    (tm1),
         .i_tm2    (tm2),
         .i_tm1_of (tm1_of),
         .i_tm2_of (tm2_of),
         .o_conf   (w_conf[g]),
         .o_shadow (w_shadow[g]),
         .o_match  (w_match[g]),
         .o_out    (outs[g])
      );
   end

   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (addr_i == 8'(2 * c + OFF_CONF)) w_rdata = 32'(w_conf[c]);
         if (addr_i == 8'(2 * c + OFF_OCR)) w_rdata = 32'(w_shadow[c]);
      end
      if (addr_i == ADDR_STATUS) w_rdata = 32'(r_status);
      if (addr_i == ADDR_IRQEN) w_rdata = 32'(r_irqen);
   end

   assign w_clr = (wr_i && addr_i == ADDR_STATUS) ? data_i[N_CH-1:0] : '0;

   // Reads sample pre-write register values, so a same-cycle write is not seen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_status <= '0;
         r_irqen  <= '0;
         data_o   <= '0;
         irq_o    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_clr) | w_match;
         if (wr_i && addr_i == ADDR_IRQEN) r_irqen <= data_i[N_CH-1:0];
         if (rd_i) data_o <= w_rdata;
         irq_o <= |(r_status & r_irqen);
      end
   end
endmodule

// File: tb/tb_oc_multi.sv
// tb_oc_multi: scenario tasks for oc_multi; register reads are scoreboarded
// through a queue of expected read data.
module tb_oc_multi;
   localparam int N_CH = 4;
   localparam int TW   = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      addr_i = '0;
   logic [31:0]     data_i = '0;
   logic            rd_i = 1'b0, wr_i = 1'b0;
   logic [31:0]     data_o;
   logic [TW-1:0]   tm1 = '0, tm2 = '0;
   logic            tm1_of = 1'b0, tm2_of = 1'b0;
   logic [N_CH-1:0] outs;
   logic            irq_o;

   int          checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always #5 clk = ~clk;

   oc_multi #(.N_CH(N_CH), .TW(TW)) dut (
      .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .rd_i(rd_i), .wr_i(wr_i),
      .data_o(data_o), .tm1(tm1), .tm2(tm2), .tm1_of(tm1_of), .tm2_of(tm2_of),
      .outs(outs), .irq_o(irq_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      addr_i = a; data_i = d; wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      addr_i = a; rd_i = 1'b1;
      tick();
      rd_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++; if (outs !== '0) begin failures++; $display("FAIL rst_outs got=%h exp=0", outs); end
      checks++; if (data_o !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", data_o); end
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
      tick(); tick();
      rst = 1'b1;
      tick();
      bus_rd(8'h40, 32'hF);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL status_mode0_match got=%h exp=%h", data_o, e); end
      checks++; if (outs !== '0) begin failures++; $display("FAIL mode0_outs got=%h exp=0", outs); end
      bus_wr(8'h40, 32'hF);
      bus_rd(8'h40, 32'h0);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL status_w1c got=%h exp=%h", data_o, e); end
   endtask

   task automatic test_set_match();
      bus_wr(8'h00, 32'hFFFF_FFE1);
      bus_wr(8'h01, 32'd10);
      bus_rd(8'h00, 32'h1);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL conf0_read got=%h exp=%h", data_o, e); end
      for (int t = 0; t <= 20; t++) begin
         tm1 = TW'(t);
         tick();
         checks++;
         if (outs[0] !== (t >= 10)) begin failures++; $display("FAIL set_match t=%0d got=%b exp=%b", t, outs[0], t >= 10); end
      end
      bus_rd(8'h40, 32'h1);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL status_ch0 got=%h exp=%h", data_o, e); end
      tick(); tick(); tick();
      checks++; if (data_o !== e) begin failures++; $display("FAIL read_hold got=%h exp=%h", data_o, e); end
   endtask

   task automatic test_rw_collision();
      addr_i = 8'h01; data_i = 32'd77; rd_i = 1'b1; wr_i = 1'b1;
      exp_q.push_back(32'd10);
      tick();
      rd_i = 1'b0; wr_i = 1'b0;
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL rw_same_cycle got=%h exp=%h", data_o, e); end
      bus_rd(8'h01, 32'd77);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL ocr_after_write got=%h exp=%h", data_o, e); end
      bus_wr(8'h20, 32'hDEAD_BEEF);
      bus_rd(8'h20, 32'h0);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", data_o, e); end
   endtask

   task automatic test_pwm();
      int high;
      high = 0;
      bus_wr(8'h02, 32'h0C);
      bus_wr(8'h03, 32'd25);
      for (int i = 0; i < 200; i++) begin
         tm2 = TW'(i % 100); tm2_of = (i % 100 == 0);
         tick();
         if (i >= 100) begin
            high += int'(outs[1]);
            checks++;
            if (outs[1] !== (i % 100 < 25)) begin failures++; $display("FAIL pwm_high t=%0d got=%b exp=%b", i % 100, outs[1], i % 100 < 25); end
         end
      end
      tm2_of = 1'b0;
      checks++; if (high != 25) begin failures++; $display("FAIL pwm_duty got=%0d exp=25", high); end
   endtask

   task automatic test_preload();
      logic ex;
      bus_wr(8'h04, 32'h1C);
      bus_wr(8'h05, 32'd25);
      for (int i = 0; i < 300; i++) begin
         tm2 = TW'(i % 100); tm2_of = (i % 100 == 0);
         addr_i = 8'h05; data_i = 32'd75;
         wr_i = (i == 150); rd_i = (i == 151);
         if (i == 151) exp_q.push_back(32'd75);
         tick();
         if (i == 151) begin
            e = exp_q.pop_front();
            checks++; if (data_o !== e) begin failures++; $display("FAIL preload_shadow_read got=%h exp=%h", data_o, e); end
         end
         if (i >= 100) begin
            ex = (i < 200) ? (i % 100 < 25) : (i % 100 < 75);
            checks++;
            if (outs[2] !== ex) begin failures++; $display("FAIL preload_pwm i=%0d got=%b exp=%b", i, outs[2], ex); end
         end
      end
      wr_i = 1'b0; rd_i = 1'b0; tm2_of = 1'b0;
   endtask

   task automatic test_toggle_irq();
      bus_wr(8'h06, 32'h3);
      bus_wr(8'h07, 32'd40);
      bus_wr(8'h41, 32'h8);
      bus_wr(8'h40, 32'hF);
      tm1 = 39;
      tick();
      checks++; if (outs[3] !== 1'b0) begin failures++; $display("FAIL tgl_before got=%b exp=0", outs[3]); end
      for (int k = 0; k < 5; k++) begin
         tm1 = 40;
         tick();
         checks++; if (outs[3] !== 1'b1) begin failures++; $display("FAIL tgl_single k=%0d got=%b exp=1", k, outs[3]); end
      end
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq_o); end
      bus_wr(8'h40, 32'h8);
      bus_rd(8'h40, 32'h0);
      e = exp_q.pop_front();
      checks++; if (32'(data_o[3]) !== e) begin failures++; $display("FAIL status_single_set got=%h exp=%h", data_o[3], e); end
      tick();
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq_o); end
      tm1 = 41;
      tick();
      tm1 = 40; addr_i = 8'h40; data_i = 32'h8; wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
      checks++; if (outs[3] !== 1'b0) begin failures++; $display("FAIL tgl_second got=%b exp=0", outs[3]); end
      bus_rd(8'h40, 32'h1);
      e = exp_q.pop_front();
      checks++; if (32'(data_o[3]) !== e) begin failures++; $display("FAIL status_set_wins got=%h exp=%h", data_o[3], e); end
      tick();
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_reassert got=%b exp=1", irq_o); end
   endtask

   task automatic test_pwml_zero_reset();
      bus_wr(8'h02, 32'h0D);
      bus_wr(8'h03, 32'd0);
      tick();
      for (int i = 0; i < 150; i++) begin
         tm2 = TW'(i % 100); tm2_of = (i % 100 == 0);
         tick();
         checks++; if (outs[1] !== 1'b1) begin failures++; $display("FAIL pwml_zero i=%0d got=%b exp=1", i, outs[1]); end
      end
      tm2_of = 1'b0;
      bus_rd(8'h01, 32'd77);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL pre_reset_read got=%h exp=%h", data_o, e); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (outs !== '0) begin failures++; $display("FAIL async_rst_outs got=%h exp=0", outs); end
      checks++; if (data_o !== '0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", data_o); end
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL async_rst_irq got=%b exp=0", irq_o); end
      tick();
      rst = 1'b1;
      tick();
      bus_rd(8'h06, 32'h0);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL conf3_after_rst got=%h exp=%h", data_o, e); end
      bus_rd(8'h41, 32'h0);
      e = exp_q.pop_front();
      checks++; if (data_o !== e) begin failures++; $display("FAIL irqen_after_rst got=%h exp=%h", data_o, e); end
   endtask

   initial begin
      test_reset();
      test_set_match();
      test_rw_collision();
      test_pwm();
      test_preload();
      test_toggle_irq();
      test_pwml_zero_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
